mc_ctrl_fsm: RTL and testbench

//  Multicycle MIPS control unit, successor to the fixed-latency controller.

---
 rtl/mc_ctrl_fsm.sv | 184 ++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control FSM with memory handshake/timeout and retired-instruction counter.
// Define MC_CTRL_EXC_EN to enable the overflow / illegal-opcode exception path.
module mc_ctrl_fsm #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             ovf,
  input  logic             mem_ready,
  output logic             pc_wr,
  output logic             pc_wr_cond,
  output logic             pc_wr_ncond,
  output logic             iord,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             ir_wr,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic             reg_wr,
  output logic             reg_dst,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic             mem_err
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  RWB    = 4'd7,
    BRANCH = 4'd8,  JUMP   = 4'd9,  ADDIEX = 4'd10, ADDIWB = 4'd11,
    EXC    = 4'd12, HALT   = 4'd13
  } state_t;

  typedef struct packed {
    logic       pc_wr;
    logic       pc_wr_cond;
    logic       pc_wr_ncond;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic       reg_wr;
    logic       reg_dst;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [TO_W:0] TO_LIM = TIMEOUT[TO_W:0];

  state_t          state_q, state_n;
  ctl_t            ctl_q;
  logic [TO_W-1:0] wait_cnt;
  logic [TO_W:0]   wait_inc;
  logic            waiting, timed_out, fetch_hit;
  logic            unused_inputs;

  assign unused_inputs = ^{zero, funct, ovf};

  function automatic ctl_t decode_ctl(input state_t s, input logic [5:0] o);
    ctl_t c;
    c = '0;
    case (s)
      FETCH:  begin c.mem_rd = 1'b1; c.alu_src_b = 2'b01; end
      DECODE: c.alu_src_b = 2'b11;
      MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      MEMRD:  begin c.mem_rd = 1'b1; c.iord = 1'b1; end
      MEMWB:  begin c.reg_wr = 1'b1; c.mem_to_reg = 1'b1; end
      MEMWR:  begin c.mem_wr = 1'b1; c.iord = 1'b1; end
      EXEC:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      RWB:    begin c.reg_wr = 1'b1; c.reg_dst = 1'b1; end
      BRANCH: begin
        c.alu_src_a   = 1'b1;
        c.alu_op      = 2'b01;
        c.pc_src      = 2'b01;
        c.pc_wr_cond  = (o == OP_BEQ);
        c.pc_wr_ncond = (o == OP_BNE);
      end
      JUMP:   begin c.pc_wr = 1'b1; c.pc_src = 2'b10; end
      ADDIEX: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      ADDIWB: c.reg_wr = 1'b1;
      EXC:    begin c.pc_wr = 1'b1; c.pc_src = 2'b11; end
      default: c = '0;
    endcase
    return c;
  endfunction

  assign waiting   = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
  assign wait_inc  = {1'b0, wait_cnt} + {{TO_W{1'b0}}, 1'b1};
  // mem_ready on the final permitted cycle takes priority over the timeout
  assign timed_out = (TIMEOUT != 0) && !mem_ready && (wait_inc >= TO_LIM);
  assign fetch_hit = (state_q == FETCH) && mem_ready;

  always_comb begin
    state_n = state_q;
    case (state_q)
      FETCH:  if (mem_ready) state_n = DECODE; else if (timed_out) state_n = HALT;
      DECODE: begin
        case (op)
          OP_RTYPE:        state_n = EXEC;
          OP_LW, OP_SW:    state_n = MEMADR;
          OP_BEQ, OP_BNE:  state_n = BRANCH;
          OP_J:            state_n = JUMP;
          OP_ADDI:         state_n = ADDIEX;
`ifdef MC_CTRL_EXC_EN
          default:         state_n = EXC;
`else
          default:         state_n = FETCH;
`endif
        endcase
      end
      MEMADR: state_n = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  if (mem_ready) state_n = MEMWB; else if (timed_out) state_n = HALT;
      MEMWB:  state_n = FETCH;
      MEMWR:  if (mem_ready) state_n = FETCH; else if (timed_out) state_n = HALT;
`ifdef MC_CTRL_EXC_EN
      EXEC:   state_n = (ovf && (funct == FN_ADD || funct == FN_SUB)) ? EXC : RWB;
      ADDIEX: state_n = ovf ? EXC : ADDIWB;
`else
      EXEC:   state_n = RWB;
      ADDIEX: state_n = ADDIWB;
`endif
      RWB, BRANCH, JUMP, ADDIWB, EXC: state_n = FETCH;
      HALT:   state_n = HALT;
      default: state_n = FETCH;
    endcase
  end

  // Outputs are registered from the next state; only the fetch strobes follow mem_ready live
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FETCH;
      ctl_q    <= decode_ctl(FETCH, 6'd0);
      retired  <= '0;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state_q <= state_n;
      ctl_q   <= decode_ctl(state_n, op);
      if (state_n == FETCH && state_q != FETCH && state_q != EXC && state_q != HALT)
        retired <= retired + CNT_W'(1);
      if (state_n != state_q || mem_ready)
        wait_cnt <= '0;
      else if (waiting)
        wait_cnt <= wait_cnt + TO_W'(1);
      if (state_n == HALT && state_q != HALT)
        mem_err <= 1'b1;
    end
  end

  assign state       = state_q;
  assign pc_wr       = rst_n & (ctl_q.pc_wr | fetch_hit);
  assign ir_wr       = rst_n & fetch_hit;
  assign pc_wr_cond  = rst_n & ctl_q.pc_wr_cond;
  assign pc_wr_ncond = rst_n & ctl_q.pc_wr_ncond;
  assign iord        = rst_n & ctl_q.iord;
  assign mem_rd      = rst_n & ctl_q.mem_rd;
  assign mem_wr      = rst_n & ctl_q.mem_wr;
  assign mem_to_reg  = rst_n & ctl_q.mem_to_reg;
  assign alu_src_a   = rst_n & ctl_q.alu_src_a;
  assign reg_wr      = rst_n & ctl_q.reg_wr;
  assign reg_dst     = rst_n & ctl_q.reg_dst;
  assign alu_src_b   = {2{rst_n}} & ctl_q.alu_src_b;
  assign alu_op      = {2{rst_n}} & ctl_q.alu_op;
  assign pc_src      = {2{rst_n}} & ctl_q.pc_src;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: stimulus queues per-cycle expectations, a negedge monitor checks them.
// Exercises the MC_CTRL_EXC_EN path when that macro is defined.
module tb_mc_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  op = '0, funct = '0;
  logic        zero = 1'b0, ovf = 1'b0, mem_ready = 1'b0;
  logic        pc_wr, pc_wr_cond, pc_wr_ncond, iord, mem_rd, mem_wr, ir_wr;
  logic        mem_to_reg, alu_src_a, reg_wr, reg_dst, mem_err;
  logic [1:0]  alu_src_b, alu_op, pc_src;
  logic [3:0]  state;
  logic [31:0] retired;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.CNT_W(32), .TIMEOUT(16), .TO_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .ovf(ovf),
    .mem_ready(mem_ready), .pc_wr(pc_wr), .pc_wr_cond(pc_wr_cond),
    .pc_wr_ncond(pc_wr_ncond), .iord(iord), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .ir_wr(ir_wr), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .reg_wr(reg_wr),
    .reg_dst(reg_dst), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .state(state), .retired(retired), .mem_err(mem_err)
  );

  typedef struct {
    logic [3:0]  st;
    logic [16:0] ctl;
    logic [31:0] ret;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_ret = '0;
  logic        exp_err = 1'b0;

  wire [16:0] act_ctl = {pc_wr, pc_wr_cond, pc_wr_ncond, iord, mem_rd, mem_wr, ir_wr,
                         mem_to_reg, alu_src_a, reg_wr, reg_dst, alu_src_b, alu_op, pc_src};

  // Reference control table, written from the state descriptions
  function automatic logic [16:0] exp_ctl(input logic [3:0] st, input logic [5:0] o, input logic rdy);
    logic pcw, pcc, pcn, io, mrd, mwr, irw, m2r, asa, rw, rd;
    logic [1:0] asb, aop, psrc;
    {pcw, pcc, pcn, io, mrd, mwr, irw, m2r, asa, rw, rd} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      4'd0:  begin mrd = 1'b1; asb = 2'b01; pcw = rdy; irw = rdy; end
      4'd1:  asb = 2'b11;
      4'd2:  begin asa = 1'b1; asb = 2'b10; end
      4'd3:  begin mrd = 1'b1; io = 1'b1; end
      4'd4:  begin rw = 1'b1; m2r = 1'b1; end
      4'd5:  begin mwr = 1'b1; io = 1'b1; end
      4'd6:  begin asa = 1'b1; aop = 2'b10; end
      4'd7:  begin rw = 1'b1; rd = 1'b1; end
      4'd8:  begin asa = 1'b1; aop = 2'b01; psrc = 2'b01;
                   pcc = (o == 6'b000100); pcn = (o == 6'b000101); end
      4'd9:  begin pcw = 1'b1; psrc = 2'b10; end
      4'd10: begin asa = 1'b1; asb = 2'b10; end
      4'd11: rw = 1'b1;
      4'd12: begin pcw = 1'b1; psrc = 2'b11; end
      default: ;
    endcase
    return {pcw, pcc, pcn, io, mrd, mwr, irw, m2r, asa, rw, rd, asb, aop, psrc};
  endfunction

  task automatic applyStimulus(input logic [5:0] o, input logic rdy, input logic z,
                               input logic v, input logic [3:0] st);
    exp_t e;
    op = o; mem_ready = rdy; zero = z; ovf = v;
    e.st  = st;
    e.ctl = rst_n ? exp_ctl(st, o, rdy) : 17'd0;
    e.ret = exp_ret;
    e.err = exp_err;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("state",   32'(state),   32'(e.st));
        checkOutput("ctl",     32'(act_ctl), 32'(e.ctl));
        checkOutput("retired", retired,      e.ret);
        checkOutput("mem_err", 32'(mem_err), 32'(e.err));
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    @(posedge clk); #1;
    // reset holds everything at zero even with mem_ready high
    applyStimulus(6'h00, 1'b1, 1'b0, 1'b0, 4'd0);
    applyStimulus(6'h00, 1'b1, 1'b0, 1'b0, 4'd0);
    rst_n = 1'b1;

    funct = 6'h20;
    applyStimulus(6'h00, 1'b1, 1'b0, 1'b0, 4'd0);
    applyStimulus(6'h00, 1'b1, 1'b0, 1'b0, 4'd1);
    applyStimulus(6'h00, 1'b1, 1'b0, 1'b0, 4'd6);
    applyStimulus(6'h00, 1'b1, 1'b0, 1'b0, 4'd7);
    exp_ret = 32'd1;

    // lw with three wait cycles
    applyStimulus(6'h23, 1'b1, 1'b0, 1'b0, 4'd0);
    applyStimulus(6'h23, 1'b1, 1'b0, 1'b0, 4'd1);
    applyStimulus(6'h23, 1'b1, 1'b0, 1'b0, 4'd2);
    for (int i = 0; i < 3; i++) applyStimulus(6'h23, 1'b0, 1'b0, 1'b0, 4'd3);
    applyStimulus(6'h23, 1'b1, 1'b0, 1'b0, 4'd3);
    applyStimulus(6'h23, 1'b1, 1'b0, 1'b0, 4'd4);
    exp_ret = 32'd2;

    applyStimulus(6'h2B, 1'b1, 1'b0, 1'b0, 4'd0);
    applyStimulus(6'h2B, 1'b1, 1'b0, 1'b0, 4'd1);
    applyStimulus(6'h2B, 1'b1, 1'b0, 1'b0, 4'd2);
    applyStimulus(6'h2B, 1'b0, 1'b0, 1'b0, 4'd5);
    applyStimulus(6'h2B, 1'b1, 1'b0, 1'b0, 4'd5);
    exp_ret = 32'd3;

    applyStimulus(6'h04, 1'b1, 1'b1, 1'b0, 4'd0);
    applyStimulus(6'h04, 1'b1, 1'b1, 1'b0, 4'd1);
    applyStimulus(6'h04, 1'b1, 1'b1, 1'b0, 4'd8);
    exp_ret = 32'd4;
    applyStimulus(6'h05, 1'b1, 1'b1, 1'b0, 4'd0);
    applyStimulus(6'h05, 1'b1, 1'b1, 1'b0, 4'd1);
    applyStimulus(6'h05, 1'b1, 1'b1, 1'b0, 4'd8);
    exp_ret = 32'd5;

    applyStimulus(6'h02, 1'b1, 1'b0, 1'b0, 4'd0);
    applyStimulus(6'h02, 1'b1, 1'b0, 1'b0, 4'd1);
    applyStimulus(6'h02, 1'b1, 1'b0, 1'b0, 4'd9);
    exp_ret = 32'd6;

    applyStimulus(6'h08, 1'b1, 1'b0, 1'b0, 4'd0);
    applyStimulus(6'h08, 1'b1, 1'b0, 1'b0, 4'd1);
    applyStimulus(6'h08, 1'b1, 1'b0, 1'b0, 4'd10);
    applyStimulus(6'h08, 1'b1, 1'b0, 1'b0, 4'd11);
    exp_ret = 32'd7;

`ifdef MC_CTRL_EXC_EN
    applyStimulus(6'h3F, 1'b1, 1'b0, 1'b0, 4'd0);
    applyStimulus(6'h3F, 1'b1, 1'b0, 1'b0, 4'd1);
    applyStimulus(6'h3F, 1'b1, 1'b0, 1'b0, 4'd12);
    applyStimulus(6'h08, 1'b1, 1'b0, 1'b1, 4'd0);
    applyStimulus(6'h08, 1'b1, 1'b0, 1'b1, 4'd1);
    applyStimulus(6'h08, 1'b1, 1'b0, 1'b1, 4'd10);
    applyStimulus(6'h08, 1'b1, 1'b0, 1'b1, 4'd12);
    applyStimulus(6'h00, 1'b1, 1'b0, 1'b1, 4'd0);
    applyStimulus(6'h00, 1'b1, 1'b0, 1'b1, 4'd1);
    applyStimulus(6'h00, 1'b1, 1'b0, 1'b1, 4'd6);
    applyStimulus(6'h00, 1'b1, 1'b0, 1'b1, 4'd12);
`else
    applyStimulus(6'h3F, 1'b1, 1'b0, 1'b0, 4'd0);
    applyStimulus(6'h3F, 1'b1, 1'b0, 1'b0, 4'd1);
    exp_ret = 32'd8;
    applyStimulus(6'h08, 1'b1, 1'b0, 1'b1, 4'd0);
    applyStimulus(6'h08, 1'b1, 1'b0, 1'b1, 4'd1);
    applyStimulus(6'h08, 1'b1, 1'b0, 1'b1, 4'd10);
    applyStimulus(6'h08, 1'b1, 1'b0, 1'b1, 4'd11);
    exp_ret = 32'd9;
`endif

    // reset in the middle of a store wait
    applyStimulus(6'h2B, 1'b1, 1'b0, 1'b0, 4'd0);
    applyStimulus(6'h2B, 1'b1, 1'b0, 1'b0, 4'd1);
    applyStimulus(6'h2B, 1'b1, 1'b0, 1'b0, 4'd2);
    applyStimulus(6'h2B, 1'b0, 1'b0, 1'b0, 4'd5);
    rst_n = 1'b0;
    exp_ret = 32'd0;
    applyStimulus(6'h2B, 1'b1, 1'b0, 1'b0, 4'd0);
    applyStimulus(6'h2B, 1'b1, 1'b0, 1'b0, 4'd0);
    rst_n = 1'b1;
    applyStimulus(6'h02, 1'b1, 1'b0, 1'b0, 4'd0);
    applyStimulus(6'h02, 1'b1, 1'b0, 1'b0, 4'd1);
    applyStimulus(6'h02, 1'b1, 1'b0, 1'b0, 4'd9);
    exp_ret = 32'd1;

    // mem_ready arrives on the last allowed fetch cycle
    for (int i = 0; i < 15; i++) applyStimulus(6'h02, 1'b0, 1'b0, 1'b0, 4'd0);
    applyStimulus(6'h02, 1'b1, 1'b0, 1'b0, 4'd0);
    applyStimulus(6'h02, 1'b1, 1'b0, 1'b0, 4'd1);
    applyStimulus(6'h02, 1'b1, 1'b0, 1'b0, 4'd9);
    exp_ret = 32'd2;

    for (int i = 0; i < 16; i++) applyStimulus(6'h02, 1'b0, 1'b0, 1'b0, 4'd0);
    exp_err = 1'b1;
    applyStimulus(6'h02, 1'b1, 1'b0, 1'b0, 4'd13);
    applyStimulus(6'h02, 1'b1, 1'b0, 1'b0, 4'd13);

    rst_n = 1'b0;
    exp_ret = 32'd0;
    exp_err = 1'b0;
    applyStimulus(6'h00, 1'b0, 1'b0, 1'b0, 4'd0);
    rst_n = 1'b1;
    applyStimulus(6'h00, 1'b1, 1'b0, 1'b0, 4'd0);
    applyStimulus(6'h00, 1'b1, 1'b0, 1'b0, 4'd1);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
